jag_lightpen_latch: RTL and testbench

Console-side light-pen receiver: synchronizes the two light-pen strobes (LP0/LP1) into the video clock domain, qualifies them, and latches the current beam position into LPH/LPV registers once per frame. It sits beside the video timing generator and responds to strobes from the lightgun emulation. Software reads it through a small register port that provides read-to-clear status and an optional one-cycle interrupt.

---
 rtl/jag_lp_pkg.sv | 32 +++
 rtl/jag_lp_sync_filter.sv | 59 +++++
 rtl/jag_lightpen_latch.sv | 140 ++++++++++++++
 tb/tb_jag_lightpen_latch.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/jag_lp_pkg.sv
// Shared types and constants for the light-pen latch: FSM states, register
// select codes and STATUS bit positions.
package jag_lp_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_LATCHED = 2'd2
  } lp_state_e;

  localparam logic [1:0] SEL_LPH    = 2'd0;
  localparam logic [1:0] SEL_LPV    = 2'd1;
  localparam logic [1:0] SEL_STATUS = 2'd2;
  localparam logic [1:0] SEL_NONE   = 2'd3;

  localparam int ST_VALID_BIT   = 0;
  localparam int ST_SRC_BIT     = 1;
  localparam int ST_BOTH_BIT    = 2;
  localparam int ST_OVERRUN_BIT = 3;

  function automatic logic [15:0] status_word(input logic valid, input logic src,
                                              input logic both, input logic overrun);
    logic [15:0] w;
    w                 = '0;
    w[ST_VALID_BIT]   = valid;
    w[ST_SRC_BIT]     = src;
    w[ST_BOTH_BIT]    = both;
    w[ST_OVERRUN_BIT] = overrun;
    return w;
  endfunction

endpackage

// File: rtl/jag_lp_sync_filter.sv
// One light-pen strobe: 2-flop synchronizer, optional glitch filter and
// rising-edge detect. The filter is built only when JAG_LP_GLITCH_FILTER_EN is defined.
module jag_lp_sync_filter #(
  parameter int FILTER_CLKS = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic async_in,
  output logic rise
);

  logic s1_q, s1_d;
  logic s2_q, s2_d;
  logic qual_prev_q, qual_prev_d;
  logic qual;

`ifdef JAG_LP_GLITCH_FILTER_EN
  // cnt_q counts consecutive high s2 cycles before the current one, saturating at 15
  localparam logic [3:0] THRESH = 4'(FILTER_CLKS - 1);
  logic [3:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = '0;
    if (s2_q) begin
      cnt_d = (cnt_q == 4'hF) ? cnt_q : cnt_q + 4'd1;
    end
    qual = s2_q && (cnt_q >= THRESH);
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end
`else
  always_comb begin
    qual = s2_q;
  end
`endif

  always_comb begin
    s1_d        = async_in;
    s2_d        = s1_q;
    qual_prev_d = qual;
    rise        = qual & ~qual_prev_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_q        <= 1'b0;
      s2_q        <= 1'b0;
      qual_prev_q <= 1'b0;
    end else begin
      s1_q        <= s1_d;
      s2_q        <= s2_d;
      qual_prev_q <= qual_prev_d;
    end
  end

endmodule

// File: rtl/jag_lightpen_latch.sv
// Light-pen receiver: latches the beam position once per frame on a qualified
// strobe, with read-to-clear STATUS. Optional glitch filter: JAG_LP_GLITCH_FILTER_EN.
module jag_lightpen_latch
  import jag_lp_pkg::*;
#(
  parameter int FILTER_CLKS = 4,
  parameter int H_COMP      = 3,
  parameter int CNT_W       = 11
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             lp0_in,
  input  logic             lp1_in,
  input  logic [1:0]       lp_enable,
  input  logic [CNT_W-1:0] hcount,
  input  logic [CNT_W-1:0] vcount,
  input  logic             vsync,
  input  logic             irq_en,
  input  logic             rd_strobe,
  input  logic [1:0]       rd_sel,
  output logic [15:0]      rd_data,
  output logic             rd_valid,
  output logic             irq
);

  localparam logic [CNT_W-1:0] H_COMP_W = CNT_W'(H_COMP);

  logic rise0, rise1, hit0, hit1, vsync_rise, capture;
  logic [CNT_W-1:0] lph_calc;

  lp_state_e        state_q, state_d;
  logic             vsync_q, vsync_d;
  logic [CNT_W-1:0] lph_q, lph_d, lpv_q, lpv_d;
  logic             valid_q, valid_d, src_q, src_d, both_q, both_d, overrun_q, overrun_d;
  logic [15:0]      rd_data_q, rd_data_d;
  logic             rd_valid_q, rd_valid_d, irq_q, irq_d;

  jag_lp_sync_filter #(.FILTER_CLKS(FILTER_CLKS)) u_sync0 (
    .clk(clk), .reset(reset), .async_in(lp0_in), .rise(rise0)
  );
  jag_lp_sync_filter #(.FILTER_CLKS(FILTER_CLKS)) u_sync1 (
    .clk(clk), .reset(reset), .async_in(lp1_in), .rise(rise1)
  );

  always_comb begin
    state_d    = state_q;
    vsync_d    = vsync;
    lph_d      = lph_q;
    lpv_d      = lpv_q;
    valid_d    = valid_q;
    src_d      = src_q;
    both_d     = both_q;
    overrun_d  = overrun_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = rd_strobe;
    capture    = 1'b0;

    hit0       = rise0 & lp_enable[0];
    hit1       = rise1 & lp_enable[1];
    vsync_rise = vsync & ~vsync_q;
    lph_calc   = (hcount >= H_COMP_W) ? hcount - H_COMP_W : '0;

    // A vsync rise in the same cycle as a hit re-arms and drops the hit
    case (state_q)
      ST_IDLE:    state_d = ST_ARMED;
      ST_ARMED: begin
        if (!vsync_rise && (hit0 || hit1)) begin
          capture = 1'b1;
          state_d = ST_LATCHED;
        end
      end
      ST_LATCHED: if (vsync_rise) state_d = ST_ARMED;
      default:    state_d = ST_IDLE;
    endcase
    if (lp_enable == 2'b00) begin
      state_d = ST_IDLE;
      capture = 1'b0;
    end

    if (rd_strobe) begin
      case (rd_sel)
        SEL_LPH:    rd_data_d = 16'(lph_q);
        SEL_LPV:    rd_data_d = 16'(lpv_q);
        SEL_STATUS: rd_data_d = status_word(valid_q, src_q, both_q, overrun_q);
        SEL_NONE:   rd_data_d = '0;
        default:    rd_data_d = '0;
      endcase
      if (rd_sel == SEL_STATUS) begin
        valid_d   = 1'b0;
        both_d    = 1'b0;
        overrun_d = 1'b0;
      end
    end

    // Capture is applied after the read clear so its bits survive
    if (capture) begin
      lph_d     = lph_calc;
      lpv_d     = vcount;
      overrun_d = valid_q;
      valid_d   = 1'b1;
      src_d     = ~hit0;
      both_d    = hit0 & hit1;
    end

    irq_d = capture & irq_en;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      vsync_q    <= 1'b0;
      lph_q      <= '0;
      lpv_q      <= '0;
      valid_q    <= 1'b0;
      src_q      <= 1'b0;
      both_q     <= 1'b0;
      overrun_q  <= 1'b0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      irq_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      vsync_q    <= vsync_d;
      lph_q      <= lph_d;
      lpv_q      <= lpv_d;
      valid_q    <= valid_d;
      src_q      <= src_d;
      both_q     <= both_d;
      overrun_q  <= overrun_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      irq_q      <= irq_d;
    end
  end

  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;
  assign irq      = irq_q;

endmodule

// File: tb/tb_jag_lightpen_latch.sv
// Self-checking bench for jag_lightpen_latch: directed scenarios with literal
// expectations plus randomized traffic checked every cycle against a sample-history model.
module tb_jag_lightpen_latch;

  localparam int CNT_W       = 11;
  localparam int H_COMP      = 3;
  localparam int FILTER_CLKS = 4;
`ifdef JAG_LP_GLITCH_FILTER_EN
  localparam int QLEN = FILTER_CLKS;
`else
  localparam int QLEN = 1;
`endif
  localparam int PLEN = QLEN + 1;
  localparam int HN   = 20;

  logic             clk = 1'b0;
  logic             reset;
  logic             lp0_in, lp1_in;
  logic [1:0]       lp_enable;
  logic [CNT_W-1:0] hcount, vcount;
  logic             vsync, irq_en, rd_strobe;
  logic [1:0]       rd_sel;
  logic [15:0]      rd_data;
  logic             rd_valid, irq;

  jag_lightpen_latch #(.FILTER_CLKS(FILTER_CLKS), .H_COMP(H_COMP), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .lp0_in(lp0_in), .lp1_in(lp1_in), .lp_enable(lp_enable),
    .hcount(hcount), .vcount(vcount), .vsync(vsync), .irq_en(irq_en),
    .rd_strobe(rd_strobe), .rd_sel(rd_sel), .rd_data(rd_data), .rd_valid(rd_valid), .irq(irq)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;
  int irq_cnt = 0;

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // ---------------- behavioural model ----------------
  // h0/h1[k] hold the input sampled k+1 edges ago; the qualified level seen at an
  // edge is the input sampled two edges earlier, held for QLEN consecutive samples.
  bit h0 [HN];
  bit h1 [HN];
  bit m_vs_prev;
  int m_mode;            // 0 idle, 1 armed, 2 latched
  int m_lph, m_lpv;
  bit m_valid, m_src, m_both, m_over;
  int e_rd_data;
  bit e_rd_valid, e_irq;
  bit r0, r1, mh0, mh1, vr, cap, old_valid;

  function automatic bit qual_at(input int port, input int off);
    bit q = 1'b1;
    for (int k = off; k < off + QLEN; k++) q &= (port == 0) ? h0[k] : h1[k];
    return q;
  endfunction

  function automatic int m_status();
    return int'(m_valid) + 2 * int'(m_src) + 4 * int'(m_both) + 8 * int'(m_over);
  endfunction

  initial forever begin
    @(posedge clk);
    if (reset) begin
      m_mode = 0; m_lph = 0; m_lpv = 0;
      m_valid = 0; m_src = 0; m_both = 0; m_over = 0;
      e_rd_data = 0; e_rd_valid = 0; e_irq = 0; m_vs_prev = 0;
      for (int k = 0; k < HN; k++) begin h0[k] = 0; h1[k] = 0; end
    end else begin
      r0  = qual_at(0, 1) && !qual_at(0, 2);
      r1  = qual_at(1, 1) && !qual_at(1, 2);
      mh0 = r0 && lp_enable[0];
      mh1 = r1 && lp_enable[1];
      vr  = vsync && !m_vs_prev;
      cap = (lp_enable != 0) && (m_mode == 1) && (mh0 || mh1) && !vr;
      if (lp_enable == 0)           m_mode = 0;
      else if (m_mode == 0)         m_mode = 1;
      else if (cap)                 m_mode = 2;
      else if (m_mode == 2 && vr)   m_mode = 1;
      e_rd_valid = rd_strobe;
      old_valid  = m_valid;
      if (rd_strobe) begin
        case (rd_sel)
          2'd0:    e_rd_data = m_lph;
          2'd1:    e_rd_data = m_lpv;
          2'd2:    e_rd_data = m_status();
          default: e_rd_data = 0;
        endcase
        if (rd_sel == 2'd2) begin m_valid = 0; m_both = 0; m_over = 0; end
      end
      if (cap) begin
        m_lph   = (int'(hcount) >= H_COMP) ? int'(hcount) - H_COMP : 0;
        m_lpv   = int'(vcount);
        m_over  = old_valid;
        m_valid = 1;
        m_src   = !mh0;
        m_both  = mh0 && mh1;
      end
      e_irq = cap && irq_en;
      for (int k = HN - 1; k > 0; k--) begin h0[k] = h0[k-1]; h1[k] = h1[k-1]; end
      h0[0] = lp0_in;
      h1[0] = lp1_in;
      m_vs_prev = vsync;
    end
  end

  // ---------------- per-cycle compare ----------------
  initial forever begin
    @(negedge clk);
    check("irq", int'(irq), int'(e_irq));
    check("rd_valid", int'(rd_valid), int'(e_rd_valid));
    if (rd_valid && e_rd_valid) check("rd_data", int'(rd_data), e_rd_data);
    if (irq) irq_cnt++;
  end

  // ---------------- directed + random stimulus ----------------
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse(input bit a, input bit b, input int len);
    lp0_in = a; lp1_in = b;
    tick(len);
    lp0_in = 0; lp1_in = 0;
    tick(QLEN + 6);
  endtask

  task automatic rd(input logic [1:0] sel, output int v);
    rd_sel = sel; rd_strobe = 1;
    tick(1);
    rd_strobe = 0;
    v = int'(rd_data);
    $display("read sel=%0d data=0x%04h", sel, rd_data);
  endtask

  task automatic vsync_pulse();
    vsync = 1; tick(2);
    vsync = 0; tick(2);
  endtask

  int v, c;

  initial begin
    reset = 1; lp0_in = 0; lp1_in = 0; lp_enable = 0; hcount = 0; vcount = 0;
    vsync = 0; irq_en = 1; rd_strobe = 0; rd_sel = 0;
    tick(3);
    reset = 0;
    check("reset_rd_valid", int'(rd_valid), 0);
    check("reset_irq", int'(irq), 0);
    rd(2'd0, v); check("reset_lph", v, 0);
    rd(2'd2, v); check("reset_status", v, 0);

    // single hit
    lp_enable = 2'b01; hcount = 500; vcount = 100; tick(3);
    c = irq_cnt;
    pulse(1, 0, PLEN);
    check("single_irq", irq_cnt - c, 1);
    rd(2'd0, v); check("single_lph", v, 497);
    rd(2'd1, v); check("single_lpv", v, 100);

    // second hit in same frame ignored; re-arm then capture with overrun
    hcount = 800;
    pulse(1, 0, PLEN);
    check("frame_irq", irq_cnt - c, 1);
    rd(2'd0, v); check("frame_lph", v, 497);
    vsync_pulse(); hcount = 600;
    pulse(1, 0, PLEN);
    rd(2'd2, v); check("overrun_status", v, 32'h9);
    rd(2'd0, v); check("rearm_lph", v, 597);
    rd(2'd2, v); check("status_cleared", v, 0);

    // clamp boundary
    vsync_pulse(); hcount = 1; vcount = 7;
    pulse(1, 0, PLEN);
    rd(2'd0, v); check("clamp_lph", v, 0);
    rd(2'd2, v); check("clamp_status", v, 1);
    rd(2'd1, v); check("clamp_lpv", v, 7);
    rd(2'd3, v); check("sel3_zero", v, 0);

    // both ports, then LP1 alone
    lp_enable = 2'b11; vsync_pulse(); hcount = 300;
    pulse(1, 1, PLEN);
    rd(2'd2, v); check("both_status", v, 5);
    rd(2'd2, v); check("both_cleared", v, 0);
    vsync_pulse();
    pulse(0, 1, PLEN);
    rd(2'd2, v); check("lp1_status", v, 3);
    rd(2'd2, v); check("lp1_src_kept", v, 2);

    // vsync rise coincident with hit: dropped, stays armed
    vsync_pulse(); c = irq_cnt;
    lp0_in = 1; tick(QLEN + 1);
    vsync = 1; tick(PLEN);
    lp0_in = 0; vsync = 0; tick(QLEN + 6);
    check("vs_hit_irq", irq_cnt - c, 0);
    rd(2'd2, v); check("vs_hit_status", v, 2);
    pulse(1, 0, PLEN);
    check("still_armed_irq", irq_cnt - c, 1);

    // capture and STATUS read in the same cycle
    vsync_pulse();
    lp0_in = 1; tick(QLEN + 1);
    rd_sel = 2'd2; rd_strobe = 1; tick(1);
    rd_strobe = 0; v = int'(rd_data);
    check("cap_rd_old", v, 1);
    lp0_in = 0; tick(QLEN + 6);
    rd(2'd2, v); check("cap_rd_new", v, 32'h9);

`ifdef JAG_LP_GLITCH_FILTER_EN
    vsync_pulse(); c = irq_cnt;
    pulse(1, 0, FILTER_CLKS - 1);
    check("glitch_short", irq_cnt - c, 0);
    pulse(1, 0, FILTER_CLKS);
    check("glitch_long", irq_cnt - c, 1);
`endif

    // reset while latched
    vsync_pulse(); pulse(1, 0, PLEN);
    reset = 1; tick(2); reset = 0;
    check("rst_rd_valid", int'(rd_valid), 0);
    rd(2'd0, v); check("rst_lph", v, 0);
    rd(2'd1, v); check("rst_lpv", v, 0);
    rd(2'd2, v); check("rst_status", v, 0);

    // randomized traffic
    lp_enable = 2'b11; irq_en = 1;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(7) == 0) lp0_in = ~lp0_in;
      if ($urandom_range(7) == 0) lp1_in = ~lp1_in;
      if ($urandom_range(31) == 0) begin lp0_in = 1; lp1_in = 1; end
      vsync = ((i % 50) < 2);
      if ($urandom_range(199) == 0) lp_enable = 2'($urandom_range(3));
      if ($urandom_range(99) == 0) irq_en = ~irq_en;
      rd_strobe = ($urandom_range(2) == 0);
      rd_sel    = 2'($urandom_range(3));
      hcount    = (i % 37 == 0) ? CNT_W'($urandom_range(5)) : hcount + 1'b1;
      vcount    = CNT_W'($urandom);
      reset     = (i == 1500);
      tick(1);
    end
    reset = 0; rd_strobe = 0;
    tick(2);

    @(posedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
